// File: rtl/icache_slave_pkg.sv
// Shared instruction-cache types: FSM state encoding and address-field width helpers.
package icache_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REFILL  = 2'd1,
    ST_RESPOND = 2'd2
  } icache_state_e;

  function automatic int word_bits(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int idx_bits(input int num_lines);
    return $clog2(num_lines);
  endfunction

  // Byte offset is always two bits since every access is a full 32-bit word.
  function automatic int tag_bits(input int xlen, input int num_lines, input int line_words);
    return xlen - 2 - $clog2(num_lines) - $clog2(line_words);
  endfunction

endpackage

// File: rtl/pipeline_pkg.sv
// Core pipeline constants shared by fetch-side blocks.
package pipeline_pkg;

  localparam int XLEN = 32;

endpackage

// File: rtl/icache_slave_if.sv
// Core instruction-fetch handshake: master drives re/sel/addr, responder returns ack/instr.
interface icache_slave_if;

  logic                          re;
  logic [3:0]                    sel;
  logic [pipeline_pkg::XLEN-1:0] addr;
  logic                          ack;
  logic [31:0]                   instr;

  modport master (output re, output sel, output addr, input ack, input instr);
  modport slave  (input re, input sel, input addr, output ack, output instr);

endinterface

// File: rtl/icache_slave_array.sv
// Direct-mapped tag/valid/data storage with combinational read and one write port.
module icache_slave_array
  import icache_slave_pkg::*;
#(
  parameter  int NUM_LINES  = 16,
  parameter  int LINE_WORDS = 4,
  parameter  int TAG_W      = 24,
  localparam int IDX_W      = idx_bits(NUM_LINES),
  localparam int WORD_W     = word_bits(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              i_data_we,
  input  logic [IDX_W-1:0]  i_widx,
  input  logic [WORD_W-1:0] i_wword,
  input  logic [31:0]       i_wdata,
  input  logic              i_tag_we,
  input  logic [TAG_W-1:0]  i_wtag,
  input  logic              i_valid_set,
  input  logic [IDX_W-1:0]  i_ridx,
  input  logic [WORD_W-1:0] i_rword,
  output logic [31:0]       o_rdata,
  output logic [TAG_W-1:0]  o_rtag,
  output logic              o_rvalid
);

  logic [31:0]          r_data [NUM_LINES*LINE_WORDS];
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [NUM_LINES-1:0] r_valid;

  // Refill data beats land in the flattened {line, word} array.
  always_ff @(posedge clk) begin
    if (i_data_we) begin
      r_data[{i_widx, i_wword}] <= i_wdata;
    end
  end

  // Tag is written once per line, on the final refill beat.
  always_ff @(posedge clk) begin
    if (i_tag_we) begin
      r_tag[i_widx] <= i_wtag;
    end
  end

  // Flush wins over a simultaneous set so a fence.i always leaves every line invalid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= {NUM_LINES{1'b0}};
    end else if (flush) begin
      r_valid <= {NUM_LINES{1'b0}};
    end else if (i_valid_set) begin
      r_valid[i_widx] <= 1'b1;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign o_rdata  = r_data[{i_ridx, i_rword}];
  assign o_rtag   = r_tag[i_ridx];
  assign o_rvalid = r_valid[i_ridx];

endmodule

// File: rtl/icache_slave.sv
// Direct-mapped instruction cache answering core fetches; misses refill a whole line
// from word 0 with one-beat-at-a-time reads to backing memory.
module icache_slave
  import pipeline_pkg::*;
  import icache_slave_pkg::*;
#(
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              reset,
  icache_slave_if.slave     core,
  input  logic              flush,
  output logic              mem_re,
  output logic [XLEN-1:0]   mem_addr,
  input  logic [31:0]       mem_data,
  input  logic              mem_ack
);

  localparam int WORD_W = word_bits(LINE_WORDS);
  localparam int IDX_W  = idx_bits(NUM_LINES);
  localparam int TAG_W  = tag_bits(XLEN, NUM_LINES, LINE_WORDS);

  icache_state_e     r_state;
  logic              r_ack;
  logic [31:0]       r_instr;
  logic              r_mem_re;
  logic [XLEN-1:0]   r_mem_addr;
  logic [WORD_W-1:0] r_cnt;
  logic [TAG_W-1:0]  r_tag;
  logic [IDX_W-1:0]  r_idx;
  logic [WORD_W-1:0] r_word;
  logic              r_flush_seen;

  logic [TAG_W-1:0]  w_req_tag;
  logic [IDX_W-1:0]  w_req_idx;
  logic [WORD_W-1:0] w_req_word;
  logic [IDX_W-1:0]  w_rd_idx;
  logic [WORD_W-1:0] w_rd_word;
  logic [31:0]       w_rdata;
  logic [TAG_W-1:0]  w_rtag;
  logic              w_rvalid;
  logic              w_hit;
  logic              w_beat;
  logic              w_last;
  logic              w_valid_set;
  logic              w_unused;

  assign w_req_tag  = core.addr[XLEN-1 -: TAG_W];
  assign w_req_idx  = core.addr[2+WORD_W +: IDX_W];
  assign w_req_word = core.addr[2 +: WORD_W];
  assign w_unused   = ^{core.sel, core.addr[1:0]};

  // Lookups read at the incoming address; during refill the array serves the latched request.
  always_comb begin
    w_rd_idx  = r_idx;
    w_rd_word = r_word;
    if (r_state == ST_IDLE) begin
      w_rd_idx  = w_req_idx;
      w_rd_word = w_req_word;
    end else begin
      w_rd_idx  = r_idx;
      w_rd_word = r_word;
    end
  end

  assign w_hit       = w_rvalid && (w_rtag == w_req_tag);
  assign w_beat      = (r_state == ST_REFILL) && r_mem_re && mem_ack;
  assign w_last      = (r_cnt == WORD_W'(LINE_WORDS - 1));
  // Any flush seen during this refill keeps the new line invalid.
  assign w_valid_set = w_beat && w_last && !flush && !r_flush_seen;

  icache_slave_array #(
    .NUM_LINES  (NUM_LINES),
    .LINE_WORDS (LINE_WORDS),
    .TAG_W      (TAG_W)
  ) u_array (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .i_data_we   (w_beat),
    .i_widx      (r_idx),
    .i_wword     (r_cnt),
    .i_wdata     (mem_data),
    .i_tag_we    (w_beat && w_last),
    .i_wtag      (r_tag),
    .i_valid_set (w_valid_set),
    .i_ridx      (w_rd_idx),
    .i_rword     (w_rd_word),
    .o_rdata     (w_rdata),
    .o_rtag      (w_rtag),
    .o_rvalid    (w_rvalid)
  );

  // Fetch FSM: lookup, word-by-word refill with a dead cycle after each beat, one-cycle ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_ack        <= 1'b0;
      r_instr      <= 32'h0000_0000;
      r_mem_re     <= 1'b0;
      r_mem_addr   <= {XLEN{1'b0}};
      r_cnt        <= {WORD_W{1'b0}};
      r_tag        <= {TAG_W{1'b0}};
      r_idx        <= {IDX_W{1'b0}};
      r_word       <= {WORD_W{1'b0}};
      r_flush_seen <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ack    <= 1'b0;
          r_mem_re <= 1'b0;
          if (core.re) begin
            r_tag        <= w_req_tag;
            r_idx        <= w_req_idx;
            r_word       <= w_req_word;
            r_flush_seen <= 1'b0;
            if (w_hit) begin
              r_instr <= w_rdata;
              r_ack   <= 1'b1;
              r_state <= ST_RESPOND;
            end else begin
              r_cnt      <= {WORD_W{1'b0}};
              r_mem_re   <= 1'b1;
              r_mem_addr <= {w_req_tag, w_req_idx, {WORD_W{1'b0}}, 2'b00};
              r_state    <= ST_REFILL;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_REFILL: begin
          if (flush) begin
            r_flush_seen <= 1'b1;
          end else begin
            r_flush_seen <= r_flush_seen;
          end
          if (r_mem_re) begin
            if (mem_ack) begin
              r_mem_re <= 1'b0;
              r_cnt    <= r_cnt + WORD_W'(1);
              if (w_last) begin
                r_instr <= (r_word == WORD_W'(LINE_WORDS - 1)) ? mem_data : w_rdata;
                r_ack   <= 1'b1;
                r_state <= ST_RESPOND;
              end else begin
                r_state <= ST_REFILL;
              end
            end else begin
              r_mem_re <= 1'b1;
            end
          end else begin
            r_mem_re   <= 1'b1;
            r_mem_addr <= {r_tag, r_idx, r_cnt, 2'b00};
          end
        end
        ST_RESPOND: begin
          r_ack   <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_ack    <= 1'b0;
          r_mem_re <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign core.ack   = r_ack;
  assign core.instr = r_instr;
  assign mem_re     = r_mem_re;
  assign mem_addr   = r_mem_addr;

endmodule

// File: tb/tb_icache_slave.sv
// Directed bench for icache_slave: cold miss, hit, back-to-back, eviction, flush and reset cases.
module tb_icache_slave;

  localparam int MEM_LAT = 2;
  localparam int TIMEOUT = 200;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        mem_re;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_ack;
  logic        mem_en;

  int n_checks = 0;
  int n_fail   = 0;
  int n_beats  = 0;
  int n_core_ack = 0;
  int n_mem_re_cyc = 0;
  int cyc_now = 0;
  logic [31:0] beat_q[$];
  int          ack_cyc_q[$];

  logic [31:0] ins;
  int lat, b0, a0, r0, k;

  icache_slave_if core_if();

  icache_slave #(.NUM_LINES(16), .LINE_WORDS(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .core     (core_if),
    .flush    (flush),
    .mem_re   (mem_re),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_ack  (mem_ack)
  );

  always #5 clk = ~clk;

  // Backing memory image: line 0x100 holds 0xA0..0xA3, everything else {C0DE, addr[15:0]}.
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a[31:4] == 28'h0000010) return 32'h0000_00A0 + {30'd0, a[3:2]};
    else return {16'hC0DE, a[15:0]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory responder: ack MEM_LAT cycles after mem_re is seen high.
  initial begin : mem_model
    int wait_cnt;
    wait_cnt = 0;
    mem_ack  = 1'b0;
    mem_data = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (mem_en) begin
        mem_ack = 1'b0;
        if (mem_re && !reset) begin
          wait_cnt++;
          if (wait_cnt == MEM_LAT) begin
            mem_ack  = 1'b1;
            mem_data = mem_val(mem_addr);
            beat_q.push_back(mem_addr);
            n_beats++;
            wait_cnt = 0;
          end
        end else begin
          wait_cnt = 0;
        end
      end
    end
  end

  initial begin : monitor
    forever begin
      @(posedge clk); #3;
      cyc_now++;
      if (core_if.ack) begin
        n_core_ack++;
        ack_cyc_q.push_back(cyc_now);
      end
      if (mem_re) n_mem_re_cyc++;
    end
  end

  // Holds the request until ack is seen, then releases it one cycle later.
  task automatic fetch(input logic [31:0] a, output logic [31:0] got, output int cycles);
    core_if.re   = 1'b1;
    core_if.addr = a;
    core_if.sel  = 4'hF;
    cycles = 0;
    do begin
      @(posedge clk); #2;
      cycles++;
    end while (!core_if.ack && cycles < TIMEOUT);
    if (!core_if.ack) check_eq("fetch_timeout", 32'(core_if.ack), 32'd1);
    got = core_if.instr;
    @(posedge clk); #2;
    core_if.re = 1'b0;
  endtask

  initial begin
    mem_en = 1'b1;
    reset = 1'b1;
    flush = 1'b0;
    core_if.re = 1'b0;
    core_if.sel = 4'h0;
    core_if.addr = 32'h0;
    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_ack", 32'(core_if.ack), 32'd0);
    check_eq("rst_mem_re", 32'(mem_re), 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_instr", core_if.instr, 32'h0);
    reset = 1'b0;
    @(posedge clk); #2;

    // Cold miss: 4 beats at 0x100..0x10C; 2+3+3+3 beat cycles plus the ack cycle = 12.
    b0 = n_beats;
    fetch(32'h0000_0100, ins, lat);
    check_eq("cold_instr", ins, 32'h0000_00A0);
    check_eq("cold_lat", 32'(lat), 32'd12);
    check_eq("cold_beats", 32'(n_beats - b0), 32'd4);
    for (int i = 0; i < 4; i++) check_eq("cold_beat_addr", beat_q[b0+i], 32'h100 + 32'(i*4));

    // Hit after fill.
    r0 = n_mem_re_cyc;
    fetch(32'h0000_0108, ins, lat);
    check_eq("hit_instr", ins, 32'h0000_00A2);
    check_eq("hit_lat", 32'(lat), 32'd1);
    check_eq("hit_no_mem_re", 32'(n_mem_re_cyc - r0), 32'd0);

    // Back-to-back hits, second request presented the cycle after the first ack.
    a0 = n_core_ack;
    fetch(32'h0000_0100, ins, lat);
    check_eq("b2b_instr0", ins, 32'h0000_00A0);
    fetch(32'h0000_0104, ins, lat);
    check_eq("b2b_instr1", ins, 32'h0000_00A1);
    check_eq("b2b_ack_count", 32'(n_core_ack - a0), 32'd2);
    check_eq("b2b_ack_gap", 32'(ack_cyc_q[ack_cyc_q.size()-1] - ack_cyc_q[ack_cyc_q.size()-2]), 32'd2);

    // Conflict eviction on line 0.
    b0 = n_beats;
    fetch(32'h0000_0500, ins, lat);
    check_eq("evict_instr", ins, 32'hC0DE_0500);
    check_eq("evict_beats", 32'(n_beats - b0), 32'd4);
    b0 = n_beats;
    fetch(32'h0000_0100, ins, lat);
    check_eq("refetch_instr", ins, 32'h0000_00A0);
    check_eq("refetch_beats", 32'(n_beats - b0), 32'd4);

    // Flush on the second refill beat of line 0x200.
    b0 = n_beats;
    fork
      fetch(32'h0000_0208, ins, lat);
      begin
        k = 0;
        while (n_beats < b0 + 2 && k < TIMEOUT) begin
          @(posedge clk); #2;
          k++;
        end
        flush = 1'b1;
        @(posedge clk); #2;
        flush = 1'b0;
      end
    join
    check_eq("flushfill_instr", ins, 32'hC0DE_0208);
    check_eq("flushfill_beats", 32'(n_beats - b0), 32'd4);
    b0 = n_beats;
    fetch(32'h0000_0200, ins, lat);
    check_eq("flushfill_remiss", 32'(n_beats - b0), 32'd4);

    // Flush together with a hitting lookup: hit uses old valid bits, next lookup misses.
    b0 = n_beats;
    fork
      fetch(32'h0000_0204, ins, lat);
      begin
        flush = 1'b1;
        @(posedge clk); #2;
        flush = 1'b0;
      end
    join
    check_eq("flushidle_instr", ins, 32'hC0DE_0204);
    check_eq("flushidle_lat", 32'(lat), 32'd1);
    check_eq("flushidle_beats", 32'(n_beats - b0), 32'd0);
    b0 = n_beats;
    fetch(32'h0000_0200, ins, lat);
    check_eq("postflush_beats", 32'(n_beats - b0), 32'd4);
    check_eq("postflush_instr", ins, 32'hC0DE_0200);

    // Reset right after the first refill beat, then a stray mem_ack.
    b0 = n_beats;
    core_if.re = 1'b1;
    core_if.addr = 32'h0000_0300;
    k = 0;
    while (n_beats < b0 + 1 && k < TIMEOUT) begin
      @(posedge clk); #2;
      k++;
    end
    reset = 1'b1;
    #1;
    check_eq("midrst_ack", 32'(core_if.ack), 32'd0);
    check_eq("midrst_mem_re", 32'(mem_re), 32'd0);
    check_eq("midrst_instr", core_if.instr, 32'h0);
    core_if.re = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
    mem_en = 1'b0;
    a0 = n_core_ack;
    r0 = n_mem_re_cyc;
    mem_ack = 1'b1;
    mem_data = 32'hDEAD_BEEF;
    @(posedge clk); #2;
    mem_ack = 1'b0;
    @(posedge clk); #2;
    check_eq("stray_no_ack", 32'(n_core_ack - a0), 32'd0);
    check_eq("stray_no_mem_re", 32'(n_mem_re_cyc - r0), 32'd0);
    mem_en = 1'b1;
    b0 = n_beats;
    fetch(32'h0000_0100, ins, lat);
    check_eq("postrst_beats", 32'(n_beats - b0), 32'd4);
    check_eq("postrst_first_addr", beat_q[b0], 32'h0000_0100);
    check_eq("postrst_instr", ins, 32'h0000_00A0);
    check_eq("postrst_lat", 32'(lat), 32'd12);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
